mirfak_operand_stage: RTL and testbench
=======================================

# mirfak_operand_stage

Operand-fetch stage of the Mirfak pipeline, sitting between decode and execute. Drives the two read ports of the register file and resolves RAW hazards by bypassing from EX, MEM and WB. Stalls decode on load-use hazards. Registers the resolved operands into the ID/EX pipeline register under a valid/ready handshake.

## Interface
Parameters:
- ENABLE_BYPASS, 1: 1 = bypass from EX/MEM/WB; 0 = no bypass, stall on any pending writer in EX/MEM/WB.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  kill the instruction held in the stage register.
- id_valid_i  in  1  decode presents an instruction.
- id_ready_o  out  1  stage accepts decode instruction this cycle.
- id_pc_i  in  32  instruction PC.
- id_rs1_i / id_rs2_i  in  5  source register indices.
- id_use_rs1_i / id_use_rs2_i  in  1  source actually read; unused sources never cause hazards.
- id_rd_i  in  5  destination index.
- id_rd_we_i  in  1  instruction writes rd.
- rf_raddr_a_o / rf_raddr_b_o  out  5  register file read addresses, equal to id_rs1_i / id_rs2_i.
- rf_rdata_a_i / rf_rdata_b_i  in  32  register file read data (combinational, x0 reads 0).
- ex_rd_i, ex_rd_we_i, ex_is_load_i, ex_result_i  in  5/1/1/32  instruction in EX; result valid only when not a load.
- mem_rd_i, mem_rd_we_i, mem_data_valid_i, mem_result_i  in  5/1/1/32  instruction in MEM; result valid when mem_data_valid_i=1.
- wb_rd_i, wb_we_i, wb_data_i  in  5/1/32  writeback port, same signals driving the register file write port.
- op_valid_o  out  1  stage register holds a valid instruction.
- ex_ready_i  in  1  execute consumes the stage register.
- op_pc_o, op_rs1_data_o, op_rs2_data_o  out  32  registered PC and resolved operands.
- op_rd_o, op_rd_we_o  out  5/1  registered destination.

## Operation
- Operand resolution, per source s, combinational: if rs=0, value 0, no hazard. Else the first match in priority EX > MEM > WB > RF, where a match requires rd equal to rs and its write enable set.
- EX match: if ex_is_load_i=1, hazard; else ex_result_i.
- MEM match: if mem_data_valid_i=0, hazard; else mem_result_i.
- WB match: wb_data_i, required because the register file write lands at the clock edge.
- ENABLE_BYPASS=0: any EX/MEM/WB match is a hazard; the value is always the register file value.
- hazard = (use_rs1 & hazard_rs1) | (use_rs2 & hazard_rs2).
- advance = !op_valid_o | ex_ready_i.
- id_ready_o = advance & !hazard & !flush_i.
- Stage register update, priority order:
  1. flush_i: op_valid_o <= 0.
  2. id_valid_i & id_ready_o: load all op_* fields, op_valid_o <= 1.
  3. advance with no load (hazard or !id_valid_i): op_valid_o <= 0, which inserts a bubble.
  4. Otherwise hold all fields.
- Payload fields (pc, data, rd, rd_we) update only on load; op_rd_we_o is qualified by op_valid_o downstream.

## Timing
- Latency: 1 cycle from acceptance (id_valid_i & id_ready_o at edge N) to op_valid_o=1 after edge N.
- Reset (asynchronous): op_valid_o=0, op_pc_o=0, op_rs1_data_o=0, op_rs2_data_o=0, op_rd_o=0, op_rd_we_o=0.
- id_ready_o is combinational from hazard inputs and ex_ready_i; no combinational path from id_valid_i to id_ready_o.
- Load-use stall: exactly 1 bubble when the load is in EX; next cycle it is in MEM and bypasses once mem_data_valid_i=1.
- MEM stall persists while mem_data_valid_i=0.
- Downstream stall (ex_ready_i=0 with op_valid_o=1): op_* held stable, id_ready_o=0.
- Flush on the same cycle as a valid handshake: the instruction is not accepted (id_ready_o=0), and op_valid_o=0 next cycle.
- Reset mid-stall: the stage returns to empty; no held operands survive.

## Structure
- Shared mirfak_pkg: constant REG_ZERO=5'd0, and the struct or field widths for the bypass source triple (rd, we, data).
- One sub-module, mirfak_bypass_mux: one source index and its use flag in; value and hazard out. Instantiated twice.

## Test plan
- x1=5 in RF, no writers; issue rs1=x1, rs2=x0 -> op_rs1_data_o=5, op_rs2_data_o=0 one cycle later.
- ex_rd_i=3, ex_result_i=0xAA, mem_rd_i=3, mem_result_i=0xBB; read x3 -> 0xAA (EX wins). Same with ex_rd_we_i=0 -> 0xBB.
- Load to x4 in EX, next instruction reads x4 -> id_ready_o=0 one cycle, bubble (op_valid_o=0), then accepted with mem_result_i.
- wb_rd_i=7, wb_data_i=0x1234, RF still old value; read x7 -> 0x1234.
- ex_ready_i=0 for 3 cycles with op_valid_o=1 -> op_* stable, id_ready_o=0. Then assert flush_i -> op_valid_o=0 next cycle.
- Write to x0 pending in EX with result 0xFF, read x0 -> 0, no stall.

Source files
------------

// File: rtl/mirfak_pkg.sv
// Shared Mirfak pipeline types: register indices and the bypass source triple.
package mirfak_pkg;

  localparam int unsigned RegAddrW = 5;
  localparam int unsigned XLen     = 32;

  localparam logic [RegAddrW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [RegAddrW-1:0] rd;
    logic                we;
    logic [XLen-1:0]     data;
  } byp_src_t;

endpackage

// File: rtl/mirfak_bypass_mux.sv
// Resolves one source operand against the EX/MEM/WB writers and the register file.
module mirfak_bypass_mux
  import mirfak_pkg::*;
#(
  parameter bit EnableBypass = 1'b1
) (
  input  logic [RegAddrW-1:0] rs_i,
  input  logic                use_i,
  input  byp_src_t            ex_i,
  input  logic                ex_is_load_i,
  input  byp_src_t            mem_i,
  input  logic                mem_data_valid_i,
  input  byp_src_t            wb_i,
  input  logic [XLen-1:0]     rf_data_i,
  output logic [XLen-1:0]     value_o,
  output logic                hazard_o
);

  logic ex_match, mem_match, wb_match;
  logic raw_hazard;

  assign ex_match  = ex_i.we  && (ex_i.rd  == rs_i);
  assign mem_match = mem_i.we && (mem_i.rd == rs_i);
  assign wb_match  = wb_i.we  && (wb_i.rd  == rs_i);

  always_comb begin
    value_o    = rf_data_i;
    raw_hazard = 1'b0;
    if (rs_i == REG_ZERO) begin
      value_o = '0;
    end else if (!EnableBypass) begin
      // Without forwarding, any in-flight writer must drain to the register file first.
      raw_hazard = ex_match | mem_match | wb_match;
    end else if (ex_match) begin
      if (ex_is_load_i) raw_hazard = 1'b1;
      else              value_o    = ex_i.data;
    end else if (mem_match) begin
      if (!mem_data_valid_i) raw_hazard = 1'b1;
      else                   value_o    = mem_i.data;
    end else if (wb_match) begin
      value_o = wb_i.data;
    end
  end

  assign hazard_o = use_i & raw_hazard;

endmodule

// File: rtl/mirfak_operand_stage.sv
// Operand-fetch stage: register file read, EX/MEM/WB bypass, load-use stall and ID/EX register.
module mirfak_operand_stage
  import mirfak_pkg::*;
#(
  parameter bit ENABLE_BYPASS = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,

  input  logic                id_valid_i,
  output logic                id_ready_o,
  input  logic [XLen-1:0]     id_pc_i,
  input  logic [RegAddrW-1:0] id_rs1_i,
  input  logic [RegAddrW-1:0] id_rs2_i,
  input  logic                id_use_rs1_i,
  input  logic                id_use_rs2_i,
  input  logic [RegAddrW-1:0] id_rd_i,
  input  logic                id_rd_we_i,

  output logic [RegAddrW-1:0] rf_raddr_a_o,
  output logic [RegAddrW-1:0] rf_raddr_b_o,
  input  logic [XLen-1:0]     rf_rdata_a_i,
  input  logic [XLen-1:0]     rf_rdata_b_i,

  input  logic [RegAddrW-1:0] ex_rd_i,
  input  logic                ex_rd_we_i,
  input  logic                ex_is_load_i,
  input  logic [XLen-1:0]     ex_result_i,

  input  logic [RegAddrW-1:0] mem_rd_i,
  input  logic                mem_rd_we_i,
  input  logic                mem_data_valid_i,
  input  logic [XLen-1:0]     mem_result_i,

  input  logic [RegAddrW-1:0] wb_rd_i,
  input  logic                wb_we_i,
  input  logic [XLen-1:0]     wb_data_i,

  output logic                op_valid_o,
  input  logic                ex_ready_i,
  output logic [XLen-1:0]     op_pc_o,
  output logic [XLen-1:0]     op_rs1_data_o,
  output logic [XLen-1:0]     op_rs2_data_o,
  output logic [RegAddrW-1:0] op_rd_o,
  output logic                op_rd_we_o
);

  byp_src_t ex_src, mem_src, wb_src;
  logic [XLen-1:0] rs1_val, rs2_val;
  logic hazard_rs1, hazard_rs2, hazard;
  logic advance, load;

  logic                valid_q;
  logic [XLen-1:0]     pc_q, rs1_data_q, rs2_data_q;
  logic [RegAddrW-1:0] rd_q;
  logic                rd_we_q;

  assign ex_src  = '{rd: ex_rd_i,  we: ex_rd_we_i,  data: ex_result_i};
  assign mem_src = '{rd: mem_rd_i, we: mem_rd_we_i, data: mem_result_i};
  assign wb_src  = '{rd: wb_rd_i,  we: wb_we_i,     data: wb_data_i};

  assign rf_raddr_a_o = id_rs1_i;
  assign rf_raddr_b_o = id_rs2_i;

  mirfak_bypass_mux #(
    .EnableBypass (ENABLE_BYPASS)
  ) u_byp_rs1 (
    .rs_i             (id_rs1_i),
    .use_i            (id_use_rs1_i),
    .ex_i             (ex_src),
    .ex_is_load_i     (ex_is_load_i),
    .mem_i            (mem_src),
    .mem_data_valid_i (mem_data_valid_i),
    .wb_i             (wb_src),
    .rf_data_i        (rf_rdata_a_i),
    .value_o          (rs1_val),
    .hazard_o         (hazard_rs1)
  );

  mirfak_bypass_mux #(
    .EnableBypass (ENABLE_BYPASS)
  ) u_byp_rs2 (
    .rs_i             (id_rs2_i),
    .use_i            (id_use_rs2_i),
    .ex_i             (ex_src),
    .ex_is_load_i     (ex_is_load_i),
    .mem_i            (mem_src),
    .mem_data_valid_i (mem_data_valid_i),
    .wb_i             (wb_src),
    .rf_data_i        (rf_rdata_b_i),
    .value_o          (rs2_val),
    .hazard_o         (hazard_rs2)
  );

  assign hazard     = hazard_rs1 | hazard_rs2;
  assign advance    = !valid_q | ex_ready_i;
  // Deliberately independent of id_valid_i so ready never loops back through decode.
  assign id_ready_o = advance & !hazard & !flush_i;
  assign load       = id_valid_i & id_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      rd_q       <= '0;
      rd_we_q    <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q    <= 1'b1;
      pc_q       <= id_pc_i;
      rs1_data_q <= rs1_val;
      rs2_data_q <= rs2_val;
      rd_q       <= id_rd_i;
      rd_we_q    <= id_rd_we_i;
    end else if (advance) begin
      valid_q <= 1'b0;
    end
  end

  assign op_valid_o    = valid_q;
  assign op_pc_o       = pc_q;
  assign op_rs1_data_o = rs1_data_q;
  assign op_rs2_data_o = rs2_data_q;
  assign op_rd_o       = rd_q;
  assign op_rd_we_o    = rd_we_q;

endmodule

// File: tb/tb_mirfak_operand_stage.sv
// Directed bench for mirfak_operand_stage with hand-computed expectations.
module tb_mirfak_operand_stage;

  logic        clk, rst, flush;
  logic        id_valid, id_ready;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2, id_rd_we;
  logic [4:0]  rf_raddr_a, rf_raddr_b;
  logic [31:0] rf_rdata_a, rf_rdata_b;
  logic [4:0]  ex_rd, mem_rd, wb_rd;
  logic        ex_rd_we, ex_is_load, mem_rd_we, mem_data_valid, wb_we;
  logic [31:0] ex_result, mem_result, wb_data;
  logic        op_valid, ex_ready;
  logic [31:0] op_pc, op_rs1_data, op_rs2_data;
  logic [4:0]  op_rd;
  logic        op_rd_we;

  logic [31:0] rf [32];
  int passed = 0;
  int total  = 0;

  mirfak_operand_stage #(
    .ENABLE_BYPASS (1'b1)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .flush_i          (flush),
    .id_valid_i       (id_valid),
    .id_ready_o       (id_ready),
    .id_pc_i          (id_pc),
    .id_rs1_i         (id_rs1),
    .id_rs2_i         (id_rs2),
    .id_use_rs1_i     (id_use_rs1),
    .id_use_rs2_i     (id_use_rs2),
    .id_rd_i          (id_rd),
    .id_rd_we_i       (id_rd_we),
    .rf_raddr_a_o     (rf_raddr_a),
    .rf_raddr_b_o     (rf_raddr_b),
    .rf_rdata_a_i     (rf_rdata_a),
    .rf_rdata_b_i     (rf_rdata_b),
    .ex_rd_i          (ex_rd),
    .ex_rd_we_i       (ex_rd_we),
    .ex_is_load_i     (ex_is_load),
    .ex_result_i      (ex_result),
    .mem_rd_i         (mem_rd),
    .mem_rd_we_i      (mem_rd_we),
    .mem_data_valid_i (mem_data_valid),
    .mem_result_i     (mem_result),
    .wb_rd_i          (wb_rd),
    .wb_we_i          (wb_we),
    .wb_data_i        (wb_data),
    .op_valid_o       (op_valid),
    .ex_ready_i       (ex_ready),
    .op_pc_o          (op_pc),
    .op_rs1_data_o    (op_rs1_data),
    .op_rs2_data_o    (op_rs2_data),
    .op_rd_o          (op_rd),
    .op_rd_we_o       (op_rd_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: combinational read, x0 hardwired to zero.
  always_comb begin
    rf_rdata_a = (rf_raddr_a == 5'd0) ? 32'd0 : rf[rf_raddr_a];
    rf_rdata_b = (rf_raddr_b == 5'd0) ? 32'd0 : rf[rf_raddr_b];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd, input logic we);
    id_valid   = 1'b1;
    id_pc      = pc;
    id_rs1     = rs1;
    id_rs2     = rs2;
    id_use_rs1 = u1;
    id_use_rs2 = u2;
    id_rd      = rd;
    id_rd_we   = we;
  endtask

  task automatic clear_writers();
    ex_rd = '0; ex_rd_we = 1'b0; ex_is_load = 1'b0; ex_result = '0;
    mem_rd = '0; mem_rd_we = 1'b0; mem_data_valid = 1'b0; mem_result = '0;
    wb_rd = '0; wb_we = 1'b0; wb_data = '0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
    rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
    id_valid = 1'b0; id_pc = '0; id_rs1 = '0; id_rs2 = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_rd = '0; id_rd_we = 1'b0;
    clear_writers();

    // Reset state
    tick(); tick();
    check("rst_valid", {31'd0, op_valid}, 32'd0);
    check("rst_pc", op_pc, 32'd0);
    check("rst_rs1", op_rs1_data, 32'd0);
    check("rst_rs2", op_rs2_data, 32'd0);
    check("rst_rd", {27'd0, op_rd}, 32'd0);
    check("rst_rd_we", {31'd0, op_rd_we}, 32'd0);
    rst = 1'b0;

    // Plain RF read: x1=5, rs2=x0
    rf[1] = 32'd5;
    issue(32'h100, 5'd1, 5'd0, 1'b1, 1'b1, 5'd2, 1'b1);
    #1;
    check("rf_ready", {31'd0, id_ready}, 32'd1);
    check("raddr_a", {27'd0, rf_raddr_a}, 32'd1);
    check("raddr_b", {27'd0, rf_raddr_b}, 32'd0);
    tick();
    check("rf_valid", {31'd0, op_valid}, 32'd1);
    check("rf_pc", op_pc, 32'h100);
    check("rf_rs1", op_rs1_data, 32'd5);
    check("rf_rs2", op_rs2_data, 32'd0);
    check("rf_rd", {27'd0, op_rd}, 32'd2);
    check("rf_rd_we", {31'd0, op_rd_we}, 32'd1);

    // EX beats MEM, then MEM when EX does not write
    ex_rd = 5'd3; ex_rd_we = 1'b1; ex_result = 32'hAA;
    mem_rd = 5'd3; mem_rd_we = 1'b1; mem_data_valid = 1'b1; mem_result = 32'hBB;
    issue(32'h104, 5'd3, 5'd3, 1'b1, 1'b1, 5'd8, 1'b1);
    tick();
    check("ex_prio_rs1", op_rs1_data, 32'hAA);
    check("ex_prio_rs2", op_rs2_data, 32'hAA);
    ex_rd_we = 1'b0;
    issue(32'h108, 5'd3, 5'd3, 1'b1, 1'b1, 5'd8, 1'b1);
    tick();
    check("mem_byp_rs1", op_rs1_data, 32'hBB);
    check("mem_byp_pc", op_pc, 32'h108);

    // Load-use: load to x4 in EX, then in MEM with data late by one cycle
    clear_writers();
    ex_rd = 5'd4; ex_rd_we = 1'b1; ex_is_load = 1'b1; ex_result = 32'hDEAD;
    issue(32'h10C, 5'd4, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1);
    #1;
    check("lu_ready", {31'd0, id_ready}, 32'd0);
    tick();
    check("lu_bubble", {31'd0, op_valid}, 32'd0);
    clear_writers();
    mem_rd = 5'd4; mem_rd_we = 1'b1; mem_data_valid = 1'b0; mem_result = 32'h44;
    #1;
    check("mem_wait_ready", {31'd0, id_ready}, 32'd0);
    tick();
    check("mem_wait_bubble", {31'd0, op_valid}, 32'd0);
    mem_data_valid = 1'b1;
    #1;
    check("lu_accept_ready", {31'd0, id_ready}, 32'd1);
    tick();
    check("lu_valid", {31'd0, op_valid}, 32'd1);
    check("lu_rs1", op_rs1_data, 32'h44);
    check("lu_pc", op_pc, 32'h10C);

    // WB bypass over a stale register file value
    clear_writers();
    rf[7] = 32'h77;
    wb_rd = 5'd7; wb_we = 1'b1; wb_data = 32'h1234;
    issue(32'h110, 5'd0, 5'd7, 1'b0, 1'b1, 5'd10, 1'b0);
    tick();
    check("wb_rs2", op_rs2_data, 32'h1234);
    check("wb_rd_we", {31'd0, op_rd_we}, 32'd0);

    // Unused source never stalls, even against a load in EX
    clear_writers();
    ex_rd = 5'd5; ex_rd_we = 1'b1; ex_is_load = 1'b1;
    issue(32'h114, 5'd5, 5'd0, 1'b0, 1'b0, 5'd11, 1'b1);
    #1;
    check("unused_ready", {31'd0, id_ready}, 32'd1);
    tick();
    check("unused_pc", op_pc, 32'h114);

    // Downstream stall for three cycles, then flush
    clear_writers();
    ex_ready = 1'b0;
    issue(32'h118, 5'd1, 5'd1, 1'b1, 1'b1, 5'd12, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_ready", {31'd0, id_ready}, 32'd0);
      tick();
      check("stall_valid", {31'd0, op_valid}, 32'd1);
      check("stall_pc", op_pc, 32'h114);
      check("stall_rd", {27'd0, op_rd}, 32'd11);
    end
    flush = 1'b1;
    #1;
    check("flush_ready", {31'd0, id_ready}, 32'd0);
    tick();
    check("flush_valid", {31'd0, op_valid}, 32'd0);
    flush = 1'b0;
    ex_ready = 1'b1;

    // Pending write to x0 with nonzero result must read as zero, no stall
    ex_rd = 5'd0; ex_rd_we = 1'b1; ex_result = 32'hFF;
    issue(32'h11C, 5'd0, 5'd0, 1'b1, 1'b1, 5'd13, 1'b1);
    #1;
    check("x0_ready", {31'd0, id_ready}, 32'd1);
    tick();
    check("x0_rs1", op_rs1_data, 32'd0);
    check("x0_rs2", op_rs2_data, 32'd0);
    check("x0_pc", op_pc, 32'h11C);

    // Flush coincident with a valid handshake: not accepted
    clear_writers();
    issue(32'h120, 5'd1, 5'd0, 1'b1, 1'b0, 5'd14, 1'b1);
    flush = 1'b1;
    #1;
    check("flush_hs_ready", {31'd0, id_ready}, 32'd0);
    tick();
    check("flush_hs_valid", {31'd0, op_valid}, 32'd0);
    check("flush_hs_pc", op_pc, 32'h11C);
    flush = 1'b0;

    // No valid from decode drains to a bubble
    tick();
    check("accept_again", op_pc, 32'h120);
    id_valid = 1'b0;
    tick();
    check("idle_bubble", {31'd0, op_valid}, 32'd0);

    // Asynchronous reset in the middle of a downstream stall
    issue(32'h124, 5'd1, 5'd0, 1'b1, 1'b0, 5'd15, 1'b1);
    tick();
    ex_ready = 1'b0;
    id_valid = 1'b0;
    tick();
    check("pre_rst_valid", {31'd0, op_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, op_valid}, 32'd0);
    check("async_rst_pc", op_pc, 32'd0);
    check("async_rst_rs1", op_rs1_data, 32'd0);
    tick();
    rst = 1'b0;
    ex_ready = 1'b1;
    tick();
    check("post_rst_valid", {31'd0, op_valid}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
